// File: rtl/fifo_param_if.sv
// Handshake bundle between the producer/consumer and fifo_param. The producer and
// consumer drive the master side and the FIFO is the slave.
interface fifo_param_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             flush;
    logic             rd_en;
    logic             wr_en;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] d_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             wr_ack;
    logic             wr_err;
    logic             rd_ack;
    logic             rd_err;
    logic [CW-1:0]    data_count;

    modport master (
        output flush, rd_en, wr_en, d_in,
        input  d_out, full, empty, almost_full, almost_empty,
        input  wr_ack, wr_err, rd_ack, rd_err, data_count
    );

    modport slave (
        input  flush, rd_en, wr_en, d_in,
        output d_out, full, empty, almost_full, almost_empty,
        output wr_ack, wr_err, rd_ack, rd_err, data_count
    );
endinterface

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with threshold flags, flush and ack/err pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; leave it undefined for registered reads.
module fifo_param #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input logic         clk,
    input logic         reset_n,
    fifo_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_ack_q, rd_ack_d;
    logic          rd_err_q, rd_err_d;
    logic          wr_ack_q, wr_ack_d;
    logic          wr_err_q, wr_err_d;
    logic          full, empty, rd_accept, wr_accept;

    always_comb begin
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        rd_accept = !bus.flush && bus.rd_en && !empty;
        // A full FIFO can still take a word when a read frees a slot in the same cycle.
        wr_accept = !bus.flush && bus.wr_en && (!full || rd_accept);

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        rd_ack_d = 1'b0;
        rd_err_d = 1'b0;
        wr_ack_d = 1'b0;
        wr_err_d = 1'b0;

        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
            if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + CW'(wr_accept) - CW'(rd_accept);
            rd_ack_d = rd_accept;
            rd_err_d = bus.rd_en && !rd_accept;
            wr_ack_d = wr_accept;
            wr_err_d = bus.wr_en && !wr_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            rd_ack_q <= rd_ack_d;
            rd_err_q <= rd_err_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
        end
    end

    // Storage has no reset; contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (reset_n && wr_accept) mem[wr_ptr_q] <= bus.d_in;
    end

`ifdef FIFO_FWFT_EN
    assign bus.d_out = empty ? '0 : mem[rd_ptr_q];
`else
    logic [WIDTH-1:0] d_out_q, d_out_d;

    always_comb begin
        d_out_d = rd_accept ? mem[rd_ptr_q] : d_out_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) d_out_q <= '0;
        else          d_out_q <= d_out_d;
    end

    assign bus.d_out = d_out_q;
`endif

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
    assign bus.data_count   = count_q;
    assign bus.rd_ack       = rd_ack_q;
    assign bus.rd_err       = rd_err_q;
    assign bus.wr_ack       = wr_ack_q;
    assign bus.wr_err       = wr_err_q;
endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed vector table, hand-written corner
// sequences and random traffic, all checked against a queue-based reference model.
module tb_fifo_param;
    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    fifo_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: occupancy is just the queue length.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout;
    logic m_rack, m_rerr, m_wack, m_werr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [WIDTH-1:0] exp_dout();
`ifdef FIFO_FWFT_EN
        return (q.size() > 0) ? q[0] : '0;
`else
        return m_dout;
`endif
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_count"}, 32'(bus.data_count), 32'(q.size()));
        check({tag, "_full"},  32'(bus.full),  32'(q.size() == DEPTH));
        check({tag, "_empty"}, 32'(bus.empty), 32'(q.size() == 0));
        check({tag, "_afull"}, 32'(bus.almost_full),  32'(q.size() >= AF));
        check({tag, "_aempty"}, 32'(bus.almost_empty), 32'(q.size() <= AE));
        check({tag, "_rd_ack"}, 32'(bus.rd_ack), 32'(m_rack));
        check({tag, "_rd_err"}, 32'(bus.rd_err), 32'(m_rerr));
        check({tag, "_wr_ack"}, 32'(bus.wr_ack), 32'(m_wack));
        check({tag, "_wr_err"}, 32'(bus.wr_err), 32'(m_werr));
        check({tag, "_d_out"},  bus.d_out, exp_dout());
    endtask

    task automatic cycle(input logic fl, input logic rd, input logic wr,
                         input logic [WIDTH-1:0] din, input string tag);
        logic rd_ok, wr_ok;
        logic [WIDTH-1:0] popped;
        bus.flush = fl; bus.rd_en = rd; bus.wr_en = wr; bus.d_in = din;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
            m_rack = 0; m_rerr = 0; m_wack = 0; m_werr = 0;
        end else begin
            rd_ok = rd && (q.size() > 0);
            wr_ok = wr && ((q.size() < DEPTH) || rd_ok);
            if (rd_ok) begin
                popped = q.pop_front();
                m_dout = popped;
            end
            if (wr_ok) q.push_back(din);
            m_rack = rd_ok; m_rerr = rd && !rd_ok;
            m_wack = wr_ok; m_werr = wr && !wr_ok;
        end
        bus.flush = 0; bus.rd_en = 0; bus.wr_en = 0;
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        bus.flush = 1; bus.rd_en = 1; bus.wr_en = 1; bus.d_in = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus.flush = 0; bus.rd_en = 0; bus.wr_en = 0;
        q.delete();
        m_dout = '0; m_rack = 0; m_rerr = 0; m_wack = 0; m_werr = 0;
        compare_all(tag);
    endtask

    typedef struct {
        logic        fl, rd, wr;
        logic [31:0] din;
        logic        rack, rerr, wack, werr;
        int          cnt;
        logic [31:0] dout;   // registered-read expectation
    } vec_t;

    vec_t vecs[15];

    initial begin
        bus.flush = 0; bus.rd_en = 0; bus.wr_en = 0; bus.d_in = '0;
        m_dout = '0; m_rack = 0; m_rerr = 0; m_wack = 0; m_werr = 0;

        //               fl rd wr din            rack rerr wack werr cnt dout
        vecs[0]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,1'b1,1'b0,1'b0, 0, 32'h0};
        vecs[1]  = '{1'b0,1'b0,1'b1,32'h1000_0000,1'b0,1'b0,1'b1,1'b0, 1, 32'h0};
        vecs[2]  = '{1'b0,1'b0,1'b1,32'h2000_0000,1'b0,1'b0,1'b1,1'b0, 2, 32'h0};
        vecs[3]  = '{1'b0,1'b0,1'b1,32'h3000_0000,1'b0,1'b0,1'b1,1'b0, 3, 32'h0};
        vecs[4]  = '{1'b0,1'b0,1'b1,32'h4000_0000,1'b0,1'b0,1'b1,1'b0, 4, 32'h0};
        vecs[5]  = '{1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0, 3, 32'h1000_0000};
        vecs[6]  = '{1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0, 2, 32'h2000_0000};
        vecs[7]  = '{1'b0,1'b0,1'b1,32'h5000_0000,1'b0,1'b0,1'b1,1'b0, 3, 32'h2000_0000};
        vecs[8]  = '{1'b0,1'b0,1'b1,32'h6000_0000,1'b0,1'b0,1'b1,1'b0, 4, 32'h2000_0000};
        vecs[9]  = '{1'b0,1'b0,1'b1,32'h7000_0000,1'b0,1'b0,1'b1,1'b0, 5, 32'h2000_0000};
        vecs[10] = '{1'b1,1'b1,1'b1,32'h7777_7777,1'b0,1'b0,1'b0,1'b0, 0, 32'h2000_0000};
        vecs[11] = '{1'b0,1'b0,1'b1,32'h0000_0088,1'b0,1'b0,1'b1,1'b0, 1, 32'h2000_0000};
        vecs[12] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0, 0, 32'h0000_0088};
        vecs[13] = '{1'b0,1'b1,1'b1,32'h0000_0099,1'b0,1'b1,1'b1,1'b0, 1, 32'h0000_0088};
        vecs[14] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,1'b0,1'b0,1'b0, 0, 32'h0000_0099};

        do_reset("reset0");
        do_reset("reset1");

        for (int i = 0; i < 15; i++) begin
            string t;
            t = $sformatf("v%0d", i);
            cycle(vecs[i].fl, vecs[i].rd, vecs[i].wr, vecs[i].din, t);
            check({t, "_tbl_rd_ack"}, 32'(bus.rd_ack), 32'(vecs[i].rack));
            check({t, "_tbl_rd_err"}, 32'(bus.rd_err), 32'(vecs[i].rerr));
            check({t, "_tbl_wr_ack"}, 32'(bus.wr_ack), 32'(vecs[i].wack));
            check({t, "_tbl_wr_err"}, 32'(bus.wr_err), 32'(vecs[i].werr));
            check({t, "_tbl_count"},  32'(bus.data_count), 32'(vecs[i].cnt));
`ifndef FIFO_FWFT_EN
            check({t, "_tbl_d_out"}, bus.d_out, vecs[i].dout);
`endif
            $display("vec %0d: fl=%0b rd=%0b wr=%0b din=%h -> count=%0d d_out=%h",
                     i, vecs[i].fl, vecs[i].rd, vecs[i].wr, vecs[i].din, bus.data_count, bus.d_out);
        end

        // Fill to full from a non-zero pointer so the drain crosses the wrap.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 0, 1, 32'hA000_0000 + 32'(i), $sformatf("fill%0d", i));
            if (i == AF - 2) check("afull_below_thresh", 32'(bus.almost_full), 32'd0);
            if (i == AF - 1) check("afull_at_thresh", 32'(bus.almost_full), 32'd1);
            $display("fill %0d: count=%0d", i, bus.data_count);
        end
        cycle(0, 0, 1, 32'h1300_0000, "overflow");
        check("overflow_wr_err", 32'(bus.wr_err), 32'd1);
        check("overflow_full", 32'(bus.full), 32'd1);
        check("overflow_count", 32'(bus.data_count), 32'd16);
        cycle(0, 1, 1, 32'hBEEF_0000, "full_rw");
        check("full_rw_rd_ack", 32'(bus.rd_ack), 32'd1);
        check("full_rw_wr_ack", 32'(bus.wr_ack), 32'd1);
        check("full_rw_count", 32'(bus.data_count), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 1, 0, '0, $sformatf("drain%0d", i));
            $display("drain %0d: d_out=%h count=%0d", i, bus.d_out, bus.data_count);
        end
        check("drained_empty", 32'(bus.empty), 32'd1);

`ifdef FIFO_FWFT_EN
        cycle(0, 0, 1, 32'hA5A5_A5A5, "fwft_wr");
        check("fwft_head", bus.d_out, 32'hA5A5_A5A5);
        cycle(0, 1, 0, '0, "fwft_rd");
        check("fwft_rd_ack", 32'(bus.rd_ack), 32'd1);
        check("fwft_empty_after", 32'(bus.empty), 32'd1);
`endif

        // Random traffic with alternating fill/drain bias and a mid-burst reset.
        for (int i = 0; i < 3000; i++) begin
            int rdp, wrp;
            logic fl, rd, wr;
            if (i == 1500) do_reset("reset_mid");
            rdp = ((i / 250) % 2 == 0) ? 35 : 75;
            wrp = 110 - rdp;
            fl = ($urandom_range(0, 99) < 2);
            rd = ($urandom_range(0, 99) < rdp);
            wr = ($urandom_range(0, 99) < wrp);
            cycle(fl, rd, wr, $urandom, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
